gpio_axil: RTL and testbench

- General-purpose I/O block with PIN_COUNT bidirectional pins, controlled through an AXI4-Lite slave register interface.
- Each pin is individually configured as input or tri-stated output.
- It sits on the peripheral bus and provides two interrupt lines for pin edge events.

---
 rtl/gpio_pkg.sv | 49 ++++
 rtl/gpio_sync.sv | 23 ++
 rtl/gpio_axil.sv | 150 +++++++++++++++
 tb/tb_gpio_axil.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants, types and helpers for the AXI4-Lite GPIO block.
package gpio_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   localparam logic [31:0] GPIO_MODE  = 32'h0;
   localparam logic [31:0] GPIO_IDATA = 32'h4;
   localparam logic [31:0] GPIO_ODATA = 32'h8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      SEL_MODE,
      SEL_IDATA,
      SEL_ODATA,
      SEL_NONE
   } reg_sel_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [STRB_W-1:0] strb;
   } wbeat_t;

   // Word-aligned decode; the two byte-offset bits are ignored.
   function automatic reg_sel_t reg_decode(input logic [31:0] addr);
      logic [31:0] word;
      word = {addr[31:2], 2'b00};
      case (word)
         GPIO_MODE:  return SEL_MODE;
         GPIO_IDATA: return SEL_IDATA;
         GPIO_ODATA: return SEL_ODATA;
         default:    return SEL_NONE;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] old,
                                                    input logic [DATA_W-1:0] data,
                                                    input logic [STRB_W-1:0] strb);
      logic [DATA_W-1:0] res;
      res = old;
      for (int unsigned b = 0; b < STRB_W; b++) begin
         if (strb[b]) res[b*8 +: 8] = data[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchronizer for asynchronous pad inputs.
module gpio_sync #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/gpio_axil.sv
// GPIO block with per-pin direction, AXI4-Lite register access and edge interrupts.
module gpio_axil
   import gpio_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned PIN_COUNT  = 16,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   inout  wire  [PIN_COUNT-1:0]  io_pins,
   output logic                  int0,
   output logic                  int1,
   input  logic                  s_axil_awvalid,
   output logic                  s_axil_awready,
   input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic [2:0]            s_axil_awprot,
   input  logic                  s_axil_wvalid,
   output logic                  s_axil_wready,
   input  logic [WIDTH-1:0]      s_axil_wdata,
   input  logic [WIDTH/8-1:0]    s_axil_wstrb,
   output logic                  s_axil_bvalid,
   input  logic                  s_axil_bready,
   output logic [1:0]            s_axil_bresp,
   input  logic                  s_axil_arvalid,
   output logic                  s_axil_arready,
   input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic [2:0]            s_axil_arprot,
   output logic                  s_axil_rvalid,
   input  logic                  s_axil_rready,
   output logic [WIDTH-1:0]      s_axil_rdata,
   output logic [1:0]            s_axil_rresp
);

   logic [PIN_COUNT-1:0]  mode_q, odata_q, idata, idata_prev;
   logic                  aw_full, w_full;
   logic [ADDR_WIDTH-1:0] awaddr_q;
   wbeat_t                wbeat_q;
   logic                  awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
   logic [1:0]            bresp_q, rresp_q;
   logic [WIDTH-1:0]      rdata_q;
   logic                  int0_q, int1_q;

   logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
   logic                  aw_full_n, w_full_n, bvalid_n, rvalid_n;
   reg_sel_t              wr_sel, rd_sel;
   logic [1:0]            wr_resp;
   logic [PIN_COUNT-1:0]  mode_wr, odata_wr;
   logic [DATA_W-1:0]     rd_val;

   logic                  unused_prot;
   assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

   for (genvar i = 0; i < PIN_COUNT; i++) begin : g_pad
      assign io_pins[i] = mode_q[i] ? odata_q[i] : 1'bz;
   end

   // IDATA is the synchronizer output, so it also reads back driven pins.
   gpio_sync #(.W(PIN_COUNT)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (io_pins),
      .q   (idata)
   );

   always_comb begin
      aw_hs     = s_axil_awvalid & awready_q;
      w_hs      = s_axil_wvalid & wready_q;
      b_hs      = bvalid_q & s_axil_bready;
      ar_hs     = s_axil_arvalid & arready_q;
      r_hs      = rvalid_q & s_axil_rready;
      commit    = aw_full & w_full & ~bvalid_q;
      aw_full_n = ~b_hs & (aw_full | aw_hs);
      w_full_n  = ~b_hs & (w_full | w_hs);
      bvalid_n  = ~b_hs & (bvalid_q | commit);
      rvalid_n  = ar_hs | (rvalid_q & ~r_hs);
      wr_sel    = reg_decode(32'(awaddr_q));
      rd_sel    = reg_decode(32'(s_axil_araddr));
      wr_resp   = (wr_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
      mode_wr   = PIN_COUNT'(strb_merge(DATA_W'(mode_q), wbeat_q.data, wbeat_q.strb));
      odata_wr  = PIN_COUNT'(strb_merge(DATA_W'(odata_q), wbeat_q.data, wbeat_q.strb));
      rd_val    = '0;
      case (rd_sel)
         SEL_MODE:  rd_val = DATA_W'(mode_q);
         SEL_IDATA: rd_val = DATA_W'(idata);
         SEL_ODATA: rd_val = DATA_W'(odata_q);
         default:   rd_val = '0;
      endcase
   end

   // Ready flags are registered from next-state so they are low during reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q     <= '0;
         odata_q    <= '0;
         idata_prev <= '0;
         aw_full    <= 1'b0;
         w_full     <= 1'b0;
         awaddr_q   <= '0;
         wbeat_q    <= '0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         rresp_q    <= RESP_OKAY;
         rdata_q    <= '0;
         int0_q     <= 1'b0;
         int1_q     <= 1'b0;
      end else begin
         aw_full   <= aw_full_n;
         w_full    <= w_full_n;
         bvalid_q  <= bvalid_n;
         rvalid_q  <= rvalid_n;
         awready_q <= ~aw_full_n & ~bvalid_n;
         wready_q  <= ~w_full_n & ~bvalid_n;
         arready_q <= ~rvalid_n;
         if (aw_hs) awaddr_q <= s_axil_awaddr;
         if (w_hs) begin
            wbeat_q.data <= DATA_W'(s_axil_wdata);
            wbeat_q.strb <= STRB_W'(s_axil_wstrb);
         end
         if (commit) begin
            bresp_q <= wr_resp;
            if (wr_sel == SEL_MODE)  mode_q  <= mode_wr;
            if (wr_sel == SEL_ODATA) odata_q <= odata_wr;
         end
         if (ar_hs) begin
            rdata_q <= WIDTH'(rd_val);
            rresp_q <= (rd_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
         end
         idata_prev <= idata;
         int0_q     <= |(idata & ~idata_prev & ~mode_q);
         int1_q     <= |(~idata & idata_prev & ~mode_q);
      end
   end

   assign s_axil_awready = awready_q;
   assign s_axil_wready  = wready_q;
   assign s_axil_bvalid  = bvalid_q;
   assign s_axil_bresp   = bresp_q;
   assign s_axil_arready = arready_q;
   assign s_axil_rvalid  = rvalid_q;
   assign s_axil_rdata   = rdata_q;
   assign s_axil_rresp   = rresp_q;
   assign int0           = int0_q;
   assign int1           = int1_q;

endmodule

// File: tb/tb_gpio_axil.sv
// Directed bench for gpio_axil: register vector table plus pin, interrupt and handshake sequences.
module tb_gpio_axil;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wire  [15:0] io_pins;
   logic [15:0] tb_en  = '0;
   logic [15:0] tb_val = '0;

   for (genvar i = 0; i < 16; i++) begin : g_drv
      assign io_pins[i] = tb_en[i] ? tb_val[i] : 1'bz;
   end

   logic        int0, int1;
   logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
   logic        arvalid = 0, arready, rvalid, rready = 0;
   logic [3:0]  awaddr = '0, araddr = '0;
   logic [31:0] wdata = '0, rdata;
   logic [3:0]  wstrb = '0;
   logic [1:0]  bresp, rresp;

   gpio_axil #(.WIDTH(32), .PIN_COUNT(16), .ADDR_WIDTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .io_pins        (io_pins),
      .int0           (int0),
      .int1           (int1),
      .s_axil_awvalid (awvalid),
      .s_axil_awready (awready),
      .s_axil_awaddr  (awaddr),
      .s_axil_awprot  (3'b000),
      .s_axil_wvalid  (wvalid),
      .s_axil_wready  (wready),
      .s_axil_wdata   (wdata),
      .s_axil_wstrb   (wstrb),
      .s_axil_bvalid  (bvalid),
      .s_axil_bready  (bready),
      .s_axil_bresp   (bresp),
      .s_axil_arvalid (arvalid),
      .s_axil_arready (arready),
      .s_axil_araddr  (araddr),
      .s_axil_arprot  (3'b000),
      .s_axil_rvalid  (rvalid),
      .s_axil_rready  (rready),
      .s_axil_rdata   (rdata),
      .s_axil_rresp   (rresp)
   );

   int checks = 0;
   int errors = 0;
   int n_int0 = 0;
   int n_int1 = 0;

   always @(negedge clk) begin
      if (int0) n_int0++;
      if (int1) n_int1++;
   end

   typedef struct {
      bit          wr;
      logic [3:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      bit aw_done = 0;
      bit w_done  = 0;
      bit hs_aw, hs_w;
      int n = 0;
      resp    = 2'bxx;
      awaddr  = addr;
      wdata   = data;
      wstrb   = strb;
      awvalid = 1;
      wvalid  = 1;
      while (!(aw_done && w_done) && n < 20) begin
         hs_aw = awvalid && awready;
         hs_w  = wvalid && wready;
         tick();
         n++;
         if (hs_aw) begin awvalid = 0; aw_done = 1; end
         if (hs_w)  begin wvalid = 0;  w_done = 1;  end
      end
      checks++;
      if (!(aw_done && w_done)) begin
         errors++;
         $display("FAIL write_accept_timeout: addr %h aw %0d w %0d", addr, aw_done, w_done);
         awvalid = 0;
         wvalid  = 0;
         return;
      end
      bready = 1;
      n = 0;
      while (!bvalid && n < 20) begin tick(); n++; end
      if (!bvalid) begin
         errors++;
         $display("FAIL write_resp_timeout: addr %h bvalid 0 required 1", addr);
         bready = 0;
         return;
      end
      resp = bresp;
      tick();
      bready = 0;
   endtask

   task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
      bit hs = 0;
      bit done = 0;
      int n = 0;
      data    = 'x;
      resp    = 2'bxx;
      araddr  = addr;
      arvalid = 1;
      while (!done && n < 20) begin
         hs = arvalid && arready;
         tick();
         n++;
         if (hs) begin arvalid = 0; done = 1; end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL read_accept_timeout: addr %h arready 0 required 1", addr);
         arvalid = 0;
         return;
      end
      rready = 1;
      n = 0;
      while (!rvalid && n < 20) begin tick(); n++; end
      if (!rvalid) begin
         errors++;
         $display("FAIL read_resp_timeout: addr %h rvalid 0 required 1", addr);
         rready = 0;
         return;
      end
      data = rdata;
      resp = rresp;
      tick();
      rready = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  r;
      logic [31:0] d;
      int          b0, b1;

      vecs.push_back('{1'b0, 4'h0, 32'h0,        4'hF, 2'b00, 32'h0000_0000});
      vecs.push_back('{1'b0, 4'h8, 32'h0,        4'hF, 2'b00, 32'h0000_0000});
      vecs.push_back('{1'b1, 4'h0, 32'h0000_FFFF, 4'hF, 2'b00, 32'h0});
      vecs.push_back('{1'b1, 4'h8, 32'h0000_A5C3, 4'hF, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 4'h0, 32'h0,        4'hF, 2'b00, 32'h0000_FFFF});
      vecs.push_back('{1'b0, 4'h8, 32'h0,        4'hF, 2'b00, 32'h0000_A5C3});
      vecs.push_back('{1'b0, 4'hC, 32'h0,        4'hF, 2'b10, 32'h0000_0000});
      vecs.push_back('{1'b1, 4'hC, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0});
      vecs.push_back('{1'b0, 4'h0, 32'h0,        4'hF, 2'b00, 32'h0000_FFFF});
      vecs.push_back('{1'b0, 4'h8, 32'h0,        4'hF, 2'b00, 32'h0000_A5C3});
      vecs.push_back('{1'b1, 4'h4, 32'h0000_0000, 4'hF, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 4'h4, 32'h0,        4'hF, 2'b00, 32'h0000_A5C3});
      vecs.push_back('{1'b1, 4'h0, 32'hFFFF_0F0F, 4'hF, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 4'h0, 32'h0,        4'hF, 2'b00, 32'h0000_0F0F});
      vecs.push_back('{1'b1, 4'h0, 32'h0000_AA00, 4'h2, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 4'h0, 32'h0,        4'hF, 2'b00, 32'h0000_AA0F});
      vecs.push_back('{1'b1, 4'h0, 32'h0000_FFFF, 4'h3, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 4'h0, 32'h0,        4'hF, 2'b00, 32'h0000_FFFF});
      vecs.push_back('{1'b0, 4'h6, 32'h0,        4'hF, 2'b00, 32'h0000_A5C3});

      // Reset state
      repeat (3) tick();
      check("rst_awready", 32'(awready), 32'h0);
      check("rst_wready",  32'(wready),  32'h0);
      check("rst_arready", 32'(arready), 32'h0);
      check("rst_valids",  32'({bvalid, rvalid}), 32'h0);
      check("rst_ints",    32'({int0, int1}), 32'h0);
      rst = 0;
      tick();
      check("post_rst_ready", 32'({awready, wready, arready}), 32'h7);

      foreach (vecs[i]) begin
         if (vecs[i].wr) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
            check($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].resp));
         end else begin
            axi_read(vecs[i].addr, d, r);
            check($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].resp));
            check($sformatf("vec%0d_rdata", i), d, vecs[i].rdata);
         end
      end
      check("pins_out_a5c3", 32'(io_pins), 32'h0000_A5C3);

      // All inputs: bench drives the pads, IDATA follows
      axi_write(4'h0, 32'h0, 4'hF, r);
      check("mode0_bresp", 32'(r), 32'h0);
      tb_val = 16'h1234;
      tb_en  = 16'hFFFF;
      #1;
      check("pins_in_1234", 32'(io_pins), 32'h0000_1234);
      repeat (3) tick();
      axi_read(4'h4, d, r);
      check("idata_1234_rresp", 32'(r), 32'h0);
      check("idata_1234", d, 32'h0000_1234);

      // Mixed direction and byte-lane write
      tb_val = 16'h0000;
      tb_en  = 16'hFF00;
      axi_write(4'h0, 32'h0000_00FF, 4'hF, r);
      check("mode_00ff_bresp", 32'(r), 32'h0);
      axi_write(4'h8, 32'h0000_FFFF, 4'hF, r);
      check("odata_ffff_bresp", 32'(r), 32'h0);
      check("pins_mixed", 32'(io_pins), 32'h0000_00FF);
      axi_write(4'h8, 32'h0000_0000, 4'h1, r);
      check("odata_strb_bresp", 32'(r), 32'h0);
      check("pins_strb", 32'(io_pins), 32'h0000_0000);
      axi_read(4'h8, d, r);
      check("odata_strb_rdata", d, 32'h0000_FF00);

      // Interrupts on input pin 3
      tb_val = 16'h0000;
      tb_en  = 16'hFFFF;
      axi_write(4'h0, 32'h0, 4'hF, r);
      repeat (4) tick();
      b0 = n_int0;
      b1 = n_int1;
      tb_val[3] = 1'b1;
      repeat (6) tick();
      check("rise_int0", 32'(n_int0 - b0), 32'd1);
      check("rise_int1", 32'(n_int1 - b1), 32'd0);
      tb_val[3] = 1'b0;
      repeat (6) tick();
      check("fall_int0", 32'(n_int0 - b0), 32'd1);
      check("fall_int1", 32'(n_int1 - b1), 32'd1);

      // Pin 3 as output toggling: no interrupts
      tb_en = 16'hFFF7;
      axi_write(4'h0, 32'h0000_0008, 4'hF, r);
      repeat (4) tick();
      b0 = n_int0;
      b1 = n_int1;
      axi_write(4'h8, 32'h0000_0008, 4'hF, r);
      repeat (4) tick();
      axi_read(4'h4, d, r);
      check("idata_readback", d, 32'h0000_0008);
      axi_write(4'h8, 32'h0000_0000, 4'hF, r);
      repeat (6) tick();
      check("out_no_int0", 32'(n_int0 - b0), 32'd0);
      check("out_no_int1", 32'(n_int1 - b1), 32'd0);

      // AW two cycles ahead of W, bready held low
      awaddr  = 4'h8;
      awvalid = 1;
      check("e_awready", 32'(awready), 32'h1);
      tick();
      awvalid = 0;
      check("e_awready_busy", 32'(awready), 32'h0);
      tick();
      wdata  = 32'h0000_5A5A;
      wstrb  = 4'hF;
      wvalid = 1;
      check("e_wready", 32'(wready), 32'h1);
      tick();
      wvalid = 0;
      check("e_bvalid_pre", 32'(bvalid), 32'h0);
      tick();
      check("e_bvalid_rise", 32'(bvalid), 32'h1);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("e_bvalid_hold%0d", k), 32'(bvalid), 32'h1);
      end
      bready = 1;
      check("e_bresp", 32'(bresp), 32'h0);
      tick();
      bready = 0;
      check("e_bvalid_clear", 32'(bvalid), 32'h0);
      check("e_awready_again", 32'(awready), 32'h1);
      axi_read(4'h8, d, r);
      check("e_odata", d, 32'h0000_5A5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
